sample_addressing_frame: RTL and testbench

//  Trigger-armed sample address generator for swept-source A-line acquisition; next generation of the

---
 rtl/sample_addressing_frame_pkg.sv | 25 ++
 rtl/sample_addressing_frame_sync_edge_detect.sv | 33 +++
 rtl/sample_addressing_frame.sv | 190 +++++++++++++++++++
 tb/tb_sample_addressing_frame.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_addressing_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sample_addressing_frame_pkg                                     |
// | Purpose  : Shared definitions for the swept-source acquisition chain:     |
// |            FSM state encoding, default sweep/frame geometry and a small   |
// |            elaboration-time helper.                                       |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package sample_addressing_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_ACQ  = 2'd2
  } acq_state_t;

  localparam int DEF_NSAMPLES = 1170;
  localparam int DEF_NLINES   = 512;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_addressing_frame_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sample_addressing_frame_sync_edge_detect                        |
// | Purpose  : Rising-edge detector with a registered history bit. The pulse  |
// |            is sig_i & ~history, so the consumer acts on the edge in the   |
// |            same cycle it is seen.                                         |
// | Ports    : clock   - clock                                                |
// |            reset_n - asynchronous active-low reset (history cleared)      |
// |            sig_i   - level input                                          |
// |            rise_o  - high in the cycle sig_i is 1 after being 0           |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module sample_addressing_frame_sync_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/sample_addressing_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sample_addressing_frame                                         |
// | Purpose  : Trigger-armed sample address generator for A-line capture.    |
// |            An accepted trigger edge starts a sweep: SKIP dead samples,    |
// |            then NSAMPLES write addresses with a strobe. Tracks the line   |
// |            index within a frame and counts triggers dropped mid-line.     |
// | Ports    : clock, reset_n (async, active-low), sclr (sync clear)          |
// |            enable      - arms acceptance of new triggers                  |
// |            trig        - sweep trigger level, rising edge used            |
// |            addr/wr_en  - sample write address and strobe                  |
// |            line_idx    - current/next A-line index in the frame           |
// |            line_done   - pulse with the last sample of a line             |
// |            frame_done  - pulse with the last sample of line NLINES-1      |
// |            busy        - line in progress (SKIP or ACQ)                   |
// |            trig_missed - pulse the cycle after a dropped trigger          |
// |            miss_cnt    - saturating dropped-trigger count                 |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module sample_addressing_frame
  import sample_addressing_frame_pkg::*;
#(
  parameter int NSAMPLES = DEF_NSAMPLES,
  parameter int ADDR_W   = 11,
  parameter int SKIP     = 0,
  parameter int NLINES   = DEF_NLINES,
  parameter int LINE_W   = 10,
  parameter int MISS_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclr,
  input  logic              enable,
  input  logic              trig,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic [LINE_W-1:0] line_idx,
  output logic              line_done,
  output logic              frame_done,
  output logic              busy,
  output logic              trig_missed,
  output logic [MISS_W-1:0] miss_cnt
);

  // One counter serves both the skip phase and the sample phase, so it must
  // be wide enough for whichever is longer.
  localparam int CNT_W = max_int(ADDR_W, $clog2(SKIP + 1));
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(NSAMPLES - 1);
  localparam logic [CNT_W-1:0]  LAST_SKIP   = CNT_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(NLINES - 1);
  localparam acq_state_t        START_STATE = (SKIP > 0) ? ST_SKIP : ST_ACQ;

  generate
    if (NSAMPLES < 1 || NSAMPLES > (2 ** ADDR_W)) begin : g_bad_nsamples
      $error("NSAMPLES must be in 1..2**ADDR_W");
    end
    if (NLINES < 1 || NLINES > (2 ** LINE_W)) begin : g_bad_nlines
      $error("NLINES must be in 1..2**LINE_W");
    end
    if (SKIP < 0) begin : g_bad_skip
      $error("SKIP must not be negative");
    end
  endgenerate

  logic trig_rise;

  sample_addressing_frame_sync_edge_detect u_trig_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sig_i   (trig),
    .rise_o  (trig_rise)
  );

  acq_state_t        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              wr_en_q,      wr_en_d;
  logic [LINE_W-1:0] line_idx_q,   line_idx_d;
  logic              line_done_q,  line_done_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q,       busy_d;
  logic              missed_q,     missed_d;
  logic [MISS_W-1:0] miss_cnt_q,   miss_cnt_d;

  logic accept;
  logic drop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_idx_d = line_idx_q;
    miss_cnt_d = miss_cnt_q;
    missed_d   = 1'b0;
    drop       = 1'b0;
    // A disabled trigger is neither started nor counted as a miss.
    accept     = trig_rise & enable;

    if (sclr) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      line_idx_d = '0;
      miss_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = START_STATE;
            cnt_d   = '0;
          end
        end
        ST_SKIP: begin
          drop = accept;
          if (cnt_q == LAST_SKIP) begin
            state_d = ST_ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ACQ: begin
          if (cnt_q == LAST_SAMPLE) begin
            line_idx_d = (line_idx_q == LAST_LINE) ? '0 : line_idx_q + LINE_W'(1);
            cnt_d      = '0;
            // A trigger arriving with the last sample chains straight into
            // the next line instead of being dropped.
            state_d    = accept ? START_STATE : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            drop  = accept;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (drop) begin
        missed_d = 1'b1;
        if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end
      end
    end

    // Outputs are decoded from the next state so that every port is a flop.
    wr_en_d      = (state_d == ST_ACQ);
    busy_d       = (state_d != ST_IDLE);
    addr_d       = wr_en_d ? cnt_d[ADDR_W-1:0] : '0;
    line_done_d  = wr_en_d && (cnt_d == LAST_SAMPLE);
    frame_done_d = line_done_d && (line_idx_d == LAST_LINE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      line_idx_q   <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      missed_q     <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      line_idx_q   <= line_idx_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      missed_q     <= missed_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign addr        = addr_q;
  assign wr_en       = wr_en_q;
  assign line_idx    = line_idx_q;
  assign line_done   = line_done_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign trig_missed = missed_q;
  assign miss_cnt    = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_addressing_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sample_addressing_frame                                      |
// | Purpose  : Directed self-checking bench for sample_addressing_frame with  |
// |            NSAMPLES=8, SKIP=2, NLINES=4, MISS_W=2. Each stimulus cycle    |
// |            starts 1 time unit after the rising clock edge; inputs set in  |
// |            cycle c are sampled at the end of cycle c.                     |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sample_addressing_frame;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sclr;
  logic       enable;
  logic       trig;
  logic [2:0] addr;
  logic       wr_en;
  logic [1:0] line_idx;
  logic       line_done;
  logic       frame_done;
  logic       busy;
  logic       trig_missed;
  logic [1:0] miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sample_addressing_frame #(
    .NSAMPLES (8),
    .ADDR_W   (3),
    .SKIP     (2),
    .NLINES   (4),
    .LINE_W   (2),
    .MISS_W   (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sclr        (sclr),
    .enable      (enable),
    .trig        (trig),
    .addr        (addr),
    .wr_en       (wr_en),
    .line_idx    (line_idx),
    .line_done   (line_done),
    .frame_done  (frame_done),
    .busy        (busy),
    .trig_missed (trig_missed),
    .miss_cnt    (miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {busy, wr_en, addr, line_done, frame_done, line_idx}
  function automatic logic [31:0] obs();
    return 32'({busy, wr_en, addr, line_done, frame_done, line_idx});
  endfunction

  function automatic logic [31:0] miss_obs();
    return 32'({trig_missed, miss_cnt});
  endfunction

  function automatic logic [31:0] idle_vec(input int idx);
    return 32'({1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'(idx)});
  endfunction

  // Expected outputs in cycle c of an isolated line whose trigger edge is in
  // cycle 0: SKIP in cycles 1-2, samples 0..7 in cycles 3-10, idle from 11.
  function automatic logic [31:0] line_vec(input int c, input int li, input bit last_line);
    logic       b;
    logic       w;
    logic [2:0] a;
    logic       ld;
    logic [1:0] idx;
    b   = (c >= 1 && c <= 10);
    w   = (c >= 3 && c <= 10);
    a   = w ? 3'(c - 3) : 3'd0;
    ld  = (c == 10);
    idx = (c <= 10) ? 2'(li) : 2'((li + 1) % 4);
    return 32'({b, w, a, ld, ld & last_line, idx});
  endfunction

  initial begin
    reset_n = 1'b0;
    sclr    = 1'b0;
    enable  = 1'b1;
    trig    = 1'b0;

    #2;
    chk("reset outputs", obs(), 32'd0);
    chk("reset miss", miss_obs(), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post-reset idle", obs(), idle_vec(0));

    // Four spaced lines of a 4-line frame; frame_done only on line 3.
    for (int li = 0; li < 4; li++) begin
      for (int c = 0; c <= 11; c++) begin
        trig = (c == 0);
        chk($sformatf("frame l%0d c%0d", li, c), obs(), line_vec(c, li, li == 3));
        tick();
      end
    end

    // Dropped edge at addr 3, then accepted edge at addr 7 (back-to-back).
    for (int c = 0; c <= 21; c++) begin
      logic       b;
      logic       w;
      logic [2:0] a;
      logic       ld;
      logic [1:0] idx;
      trig = (c == 0 || c == 6 || c == 10);
      b    = (c >= 1 && c <= 20);
      w    = (c >= 3 && c <= 10) || (c >= 13 && c <= 20);
      a    = (c >= 3 && c <= 10) ? 3'(c - 3) : (c >= 13 && c <= 20) ? 3'(c - 13) : 3'd0;
      ld   = (c == 10 || c == 20);
      idx  = (c <= 10) ? 2'd0 : (c <= 20) ? 2'd1 : 2'd2;
      chk($sformatf("b2b line c%0d", c), obs(), 32'({b, w, a, ld, 1'b0, idx}));
      chk($sformatf("b2b miss c%0d", c), miss_obs(),
          32'({(c == 7), ((c >= 7) ? 2'd1 : 2'd0)}));
      tick();
    end

    // Disabled edge in IDLE: no start, not counted.
    for (int c = 0; c <= 3; c++) begin
      trig   = (c == 0);
      enable = 1'b0;
      chk($sformatf("disabled c%0d", c), obs(), idle_vec(2));
      chk($sformatf("disabled miss c%0d", c), miss_obs(), 32'd1);
      tick();
    end

    // enable dropped mid-line: line still completes.
    for (int c = 0; c <= 11; c++) begin
      trig   = (c == 0);
      enable = !(c >= 5);
      chk($sformatf("en-drop c%0d", c), obs(), line_vec(c, 2, 1'b0));
      tick();
    end
    enable = 1'b1;

    // Asynchronous reset in the middle of a line (addr 3, line_idx 3).
    for (int c = 0; c <= 6; c++) begin
      trig = (c == 0);
      chk($sformatf("pre-reset c%0d", c), obs(), line_vec(c, 3, 1'b1));
      if (c < 6) tick();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async reset outputs", obs(), 32'd0);
    chk("async reset miss", miss_obs(), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("after async reset", obs(), idle_vec(0));

    // One full line to move line_idx to 1.
    for (int c = 0; c <= 11; c++) begin
      trig = (c == 0);
      chk($sformatf("pre-sclr c%0d", c), obs(), line_vec(c, 0, 1'b0));
      tick();
    end

    // Drop at addr 1, then sclr at addr 5: line abandoned, everything cleared.
    for (int c = 0; c <= 12; c++) begin
      trig = (c == 0 || c == 4);
      sclr = (c == 8);
      if (c <= 8) begin
        chk($sformatf("sclr line c%0d", c), obs(), line_vec(c, 1, 1'b0));
        chk($sformatf("sclr miss c%0d", c), miss_obs(),
            32'({(c == 5), ((c >= 5) ? 2'd1 : 2'd0)}));
      end else begin
        chk($sformatf("sclr idle c%0d", c), obs(), idle_vec(0));
        chk($sformatf("sclr miss c%0d", c), miss_obs(), 32'd0);
      end
      tick();
    end
    sclr = 1'b0;

    // Four drops in one line: 2-bit counter saturates at 3.
    for (int c = 0; c <= 11; c++) begin
      logic [1:0] exp_cnt;
      trig    = (c == 0 || c == 2 || c == 4 || c == 6 || c == 8);
      exp_cnt = (c < 3) ? 2'd0 : (c < 5) ? 2'd1 : (c < 7) ? 2'd2 : 2'd3;
      chk($sformatf("sat1 line c%0d", c), obs(), line_vec(c, 0, 1'b0));
      chk($sformatf("sat1 miss c%0d", c), miss_obs(),
          32'({(c == 3 || c == 5 || c == 7 || c == 9), exp_cnt}));
      tick();
    end

    // Fifth drop: pulse still fires, count stays at 3.
    for (int c = 0; c <= 11; c++) begin
      trig = (c == 0 || c == 4);
      chk($sformatf("sat2 line c%0d", c), obs(), line_vec(c, 1, 1'b0));
      chk($sformatf("sat2 miss c%0d", c), miss_obs(), 32'({(c == 5), 2'd3}));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
